// File: rtl/rns_dual_cmp_seq.sv
// rns_dual_cmp_seq
//   Iterative sequencer for the RNS dual-threshold sign comparator. One
//   digit comparator pair (positive / negative threshold) is reused across
//   all mixed-radix digits of a value, least-significant digit first. The
//   2-bit sign state is accumulated and reported with carry-out flags for
//   range/overflow detection.
//
//   Sign encoding: 00 equal, 01 less (digit < const), 10 greater, 11 illegal.
//
// Ports
//   clk, reset                : clock, synchronous active-high reset
//   dig_valid/dig_ready       : digit handshake, dig_data is LS digit first
//   dig_last                  : final-digit marker (checked only with the option)
//   res_valid/res_ready       : result handshake
//   sign_result_pos/_neg      : accumulated sign vs positive/negative threshold
//   pos_cout/neg_cout         : OR of the respective sign bits
//   busy                      : sequencer not idle
//   res_err                   : protocol/encoding error for this result
//
// Optional feature macro: RNS_DUAL_CMP_ERR_DETECT_EN
//   Defined   : dig_last can end a value early; dig_last mismatch or any 2'b11
//               sign sets res_err.
//   Undefined : dig_last ignored, value ends on the digit count, res_err = 0.
//
// States
//   IDLE  | waiting for the first digit of a value
//   RUN   | accepting digits, idx counts accepted digits
//   DRAIN | no more digits, waiting for the 2-stage pipe to empty
//   DONE  | result valid and held until res_ready

module rns_dual_cmp_seq #(
  parameter int DATA_WIDTH = 18,
  parameter int NUM_DIGITS = 8,
  parameter logic [NUM_DIGITS*DATA_WIDTH-1:0] POS_DIGITS = '0,
  parameter logic [NUM_DIGITS*DATA_WIDTH-1:0] NEG_DIGITS = '0,
  parameter int CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dig_valid,
  output logic                  dig_ready,
  input  logic [DATA_WIDTH-1:0] dig_data,
  input  logic                  dig_last,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [1:0]            sign_result_pos,
  output logic [1:0]            sign_result_neg,
  output logic                  pos_cout,
  output logic                  neg_cout,
  output logic                  busy,
  output logic                  res_err
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_DIGITS - 1);

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      idx;
  logic                  s1_valid, s2_valid;
  logic [DATA_WIDTH-1:0] s1_data;
  logic [CNT_W-1:0]      s1_idx;
  logic [1:0]            acc_pos, acc_neg;
  logic [1:0]            cmp_pos, cmp_neg;
  logic [DATA_WIDTH-1:0] pos_tab [NUM_DIGITS];
  logic [DATA_WIDTH-1:0] neg_tab [NUM_DIGITS];
  logic                  accept, last_hit, pipe_empty, load_res, handshake;

  assign accept     = dig_valid & dig_ready;
  assign pipe_empty = ~s1_valid & ~s2_valid;
  assign load_res   = (state == DRAIN) & pipe_empty;
  assign handshake  = res_valid & res_ready;

`ifdef RNS_DUAL_CMP_ERR_DETECT_EN
  logic err_acc;
  assign last_hit = (idx == LAST_IDX) | dig_last;
`else
  logic unused_dig_last;
  assign unused_dig_last = dig_last;
  assign last_hit        = (idx == LAST_IDX);
  assign res_err         = 1'b0;
`endif

  // Unpack the threshold constants so the comparator can index them by digit.
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      pos_tab[i] = POS_DIGITS[i*DATA_WIDTH +: DATA_WIDTH];
      neg_tab[i] = NEG_DIGITS[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    cmp_pos = 2'b00;
    cmp_neg = 2'b00;
    if (s1_data < pos_tab[s1_idx])      cmp_pos = 2'b01;
    else if (s1_data > pos_tab[s1_idx]) cmp_pos = 2'b10;
    if (s1_data < neg_tab[s1_idx])      cmp_neg = 2'b01;
    else if (s1_data > neg_tab[s1_idx]) cmp_neg = 2'b10;
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = last_hit ? DRAIN : RUN;
      RUN:     if (accept && last_hit) state_nxt = DRAIN;
      DRAIN:   if (pipe_empty) state_nxt = DONE;
      DONE:    if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    dig_ready = ~reset & ((state == IDLE) | (state == RUN));
    res_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // Digit pipeline, accumulator and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      idx             <= '0;
      s1_valid        <= 1'b0;
      s1_data         <= '0;
      s1_idx          <= '0;
      s2_valid        <= 1'b0;
      acc_pos         <= 2'b00;
      acc_neg         <= 2'b00;
      sign_result_pos <= 2'b00;
      sign_result_neg <= 2'b00;
    end else begin
      s1_valid <= accept;
      s2_valid <= s1_valid;
      if (accept) begin
        s1_data <= dig_data;
        s1_idx  <= idx;
        idx     <= idx + CNT_W'(1);
      end
      // Each new digit is more significant than everything before it, so
      // any non-equal result overrides the accumulated sign.
      if (s1_valid) begin
        if (cmp_pos != 2'b00) acc_pos <= cmp_pos;
        if (cmp_neg != 2'b00) acc_neg <= cmp_neg;
      end
      if (load_res) begin
        sign_result_pos <= acc_pos;
        sign_result_neg <= acc_neg;
      end
      if (handshake) begin
        idx     <= '0;
        acc_pos <= 2'b00;
        acc_neg <= 2'b00;
      end
    end
  end

`ifdef RNS_DUAL_CMP_ERR_DETECT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err_acc <= 1'b0;
      res_err <= 1'b0;
    end else begin
      if (accept && (dig_last != (idx == LAST_IDX))) err_acc <= 1'b1;
      if (s1_valid && ((cmp_pos == 2'b11) || (cmp_neg == 2'b11) ||
                       (acc_pos == 2'b11) || (acc_neg == 2'b11)))
        err_acc <= 1'b1;
      if (load_res) res_err <= err_acc;
      if (handshake) begin
        err_acc <= 1'b0;
        res_err <= 1'b0;
      end
    end
  end
`endif

  assign pos_cout = |sign_result_pos;
  assign neg_cout = |sign_result_neg;

endmodule

// File: tb/tb_rns_dual_cmp_seq.sv
module tb_rns_dual_cmp_seq;
  localparam int DW = 8;
  localparam int ND = 4;
  localparam logic [ND*DW-1:0] POS = 32'h02_00_03_05;  // idx3..0 = 2,0,3,5
  localparam logic [ND*DW-1:0] NEG = 32'h02_04_07_01;  // idx3..0 = 2,4,7,1

  typedef logic [DW-1:0] val_t [ND];
  typedef int gap_t [ND];

  logic          clk = 1'b0;
  logic          reset;
  logic          dig_valid, dig_ready, dig_last;
  logic [DW-1:0] dig_data;
  logic          res_valid, res_ready;
  logic [1:0]    sign_result_pos, sign_result_neg;
  logic          pos_cout, neg_cout, busy, res_err;

  int   n_chk = 0;
  int   n_pass = 0;
  logic [1:0] exp_pos, exp_neg;
  logic       exp_err;
  logic       exp_armed;

  rns_dual_cmp_seq #(
    .DATA_WIDTH(DW), .NUM_DIGITS(ND), .POS_DIGITS(POS), .NEG_DIGITS(NEG)
  ) dut (
    .clk(clk), .reset(reset),
    .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_data(dig_data),
    .dig_last(dig_last),
    .res_valid(res_valid), .res_ready(res_ready),
    .sign_result_pos(sign_result_pos), .sign_result_neg(sign_result_neg),
    .pos_cout(pos_cout), .neg_cout(neg_cout),
    .busy(busy), .res_err(res_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Reference: scan digits MS to LS; the most significant non-equal digit decides.
  function automatic logic [1:0] ref_sign(input val_t d, input logic [ND*DW-1:0] k);
    logic [DW-1:0] c;
    for (int i = ND - 1; i >= 0; i--) begin
      c = k[i*DW +: DW];
      if (d[i] > c) return 2'b10;
      if (d[i] < c) return 2'b01;
    end
    return 2'b00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Result compare on every cycle the result is valid
  always @(negedge clk) begin
    if (!reset && res_valid) begin
      if (exp_armed) begin
        chk("res_pos", sign_result_pos, exp_pos);
        chk("res_neg", sign_result_neg, exp_neg);
        chk("pos_cout", pos_cout, |exp_pos);
        chk("neg_cout", neg_cout, |exp_neg);
        chk("res_err", res_err, exp_err);
      end else begin
        chk("unexpected_res_valid", res_valid, 1'b0);
      end
    end
  end

  task automatic send(input val_t d, input gap_t gaps, input int hold, input int last_at,
                      input bit use_lit, input logic [1:0] lit_pos, input logic [1:0] lit_neg);
    int lat;
    exp_pos   = ref_sign(d, POS);
    exp_neg   = ref_sign(d, NEG);
    exp_err   = 1'b0;
    exp_armed = 1'b1;
    for (int i = 0; i < ND; i++) begin
      for (int g = 0; g < gaps[i]; g++) begin
        dig_valid = 1'b0;
        tick();
        chk("no_early_valid", res_valid, 1'b0);
      end
      dig_valid = 1'b1;
      dig_data  = d[i];
      dig_last  = (i == last_at);
      chk("dig_ready_run", dig_ready, 1'b1);
      tick();
    end
    dig_valid = 1'b0;
    dig_last  = 1'b0;
    lat = 0;
    while (!res_valid && lat < 10) begin
      chk("dig_ready_drain", dig_ready, 1'b0);
      tick();
      lat++;
    end
    chk("latency", lat, 3);
    if (use_lit) begin
      chk("lit_pos", sign_result_pos, lit_pos);
      chk("lit_neg", sign_result_neg, lit_neg);
      chk("lit_pos_cout", pos_cout, |lit_pos);
      chk("lit_neg_cout", neg_cout, |lit_neg);
    end
    for (int h = 0; h < hold; h++) begin
      chk("dig_ready_done", dig_ready, 1'b0);
      chk("hold_valid", res_valid, 1'b1);
      tick();
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    exp_armed = 1'b0;
    chk("post_hs_valid", res_valid, 1'b0);
    chk("post_hs_busy", busy, 1'b0);
    chk("post_hs_ready", dig_ready, 1'b1);
  endtask

  initial begin
    val_t d;
    gap_t g;
    int   lat;
    reset = 1'b1; dig_valid = 1'b0; dig_data = '0; dig_last = 1'b0; res_ready = 1'b0;
    exp_armed = 1'b0; exp_pos = 2'b00; exp_neg = 2'b00; exp_err = 1'b0;
    tick();
    tick();
    chk("rst_dig_ready", dig_ready, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_res_err", res_err, 1'b0);
    chk("rst_pos", sign_result_pos, 2'b00);
    chk("rst_neg", sign_result_neg, 2'b00);
    chk("rst_couts", {pos_cout, neg_cout}, 2'b00);
    reset = 1'b0;
    tick();
    chk("idle_dig_ready", dig_ready, 1'b1);
    chk("idle_busy", busy, 1'b0);

    // res_ready while nothing is valid must be ignored
    res_ready = 1'b1;
    tick();
    tick();
    res_ready = 1'b0;
    chk("stray_ready_valid", res_valid, 1'b0);
    chk("stray_ready_busy", busy, 1'b0);

    g = '{0, 0, 0, 0};
    send('{8'd5, 8'd3, 8'd0, 8'd2}, g, 0, 3, 1'b1, 2'b00, 2'b01);
    send('{8'd5, 8'd3, 8'd0, 8'd3}, g, 0, 3, 1'b1, 2'b10, 2'b10);
    send('{8'd6, 8'd3, 8'd0, 8'd2}, g, 0, 3, 1'b1, 2'b10, 2'b01);

    // valid pattern 1,0,0,1,1,0,1 and a 5-cycle held result
    g = '{0, 2, 0, 1};
    send('{8'd5, 8'd3, 8'd0, 8'd2}, g, 5, 3, 1'b1, 2'b00, 2'b01);

    // reset after two digits discards the partial value
    dig_valid = 1'b1; dig_data = 8'd9; tick();
    dig_data = 8'd9; tick();
    dig_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("abort_busy", busy, 1'b0);
    chk("abort_res_valid", res_valid, 1'b0);
    chk("abort_dig_ready", dig_ready, 1'b0);
    reset = 1'b0;
    tick();
    chk("abort_idle_ready", dig_ready, 1'b1);
    g = '{0, 0, 0, 0};
    send('{8'd5, 8'd3, 8'd0, 8'd2}, g, 1, 3, 1'b1, 2'b00, 2'b01);

`ifdef RNS_DUAL_CMP_ERR_DETECT_EN
    // dig_last on the 3rd digit ends the value early with an error
    d = '{8'd5, 8'd3, 8'd0, 8'd2};
    exp_pos = ref_sign(d, POS); exp_neg = ref_sign(d, NEG);
    exp_err = 1'b1; exp_armed = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dig_valid = 1'b1; dig_data = d[i]; dig_last = (i == 2);
      tick();
    end
    dig_valid = 1'b0; dig_last = 1'b0;
    lat = 0;
    while (!res_valid && lat < 10) begin tick(); lat++; end
    chk("early_latency", lat, 3);
    chk("early_res_err", res_err, 1'b1);
    res_ready = 1'b1; tick(); res_ready = 1'b0; exp_armed = 1'b0;
    chk("early_err_clear", res_err, 1'b0);
`else
    // dig_last on the 3rd digit is ignored: a 4th digit is still awaited
    g = '{0, 0, 0, 5};
    send('{8'd5, 8'd3, 8'd0, 8'd2}, g, 0, 2, 1'b1, 2'b00, 2'b01);
    lat = 0;
    chk("no_err_default", res_err, 1'b0);
`endif

    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < ND; i++) begin
        d[i] = DW'($urandom_range(0, 7));
        g[i] = $urandom_range(0, 2);
      end
      send(d, g, $urandom_range(0, 3), 3, 1'b0, 2'b00, 2'b00);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
